// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - sequencer <-> instruction memory / datapath bundle
interface multicycle_sequencer_if #(
   parameter int PC_W  = 5,
   parameter int CNT_W = 8
);
   logic             start;
   logic [31:0]      instr;
   logic             alu_zero;
   logic [PC_W-1:0]  pc;
   logic             ir_load;
   logic [1:0]       rs_sel;
   logic [1:0]       rt_sel;
   logic             a_load;
   logic             b_load;
   logic             b_sel_imm;
   logic [31:0]      imm;
   logic [2:0]       alu_op;
   logic             alu_out_load;
   logic             reg_we;
   logic [1:0]       wr_sel;
   logic             busy;
   logic             halted;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  start, instr, alu_zero,
      output pc, ir_load, rs_sel, rt_sel, a_load, b_load, b_sel_imm, imm,
             alu_op, alu_out_load, reg_we, wr_sel, busy, halted, illegal, retired
   );

   modport slave (
      output start, instr, alu_zero,
      input  pc, ir_load, rs_sel, rt_sel, a_load, b_load, b_sel_imm, imm,
             alu_op, alu_out_load, reg_we, wr_sel, busy, halted, illegal, retired
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle control FSM for the A/B/ALUout datapath
module multicycle_sequencer #(
   parameter int IM_DEPTH = 20,
   parameter int PC_W     = 5,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic RST,
   multicycle_sequencer_if.master bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_BRANCH = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   logic [2:0]       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [31:0]      ir_q, ir_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic [5:0]         opcode, funct;
   logic               is_rtype, is_addi, is_beq, is_halt;
   logic [2:0]         r_alu_op;
   logic signed [31:0] imm_ext, br_target;
   logic               br_in_range, at_end, retire;
   logic               unused_ir_bits;

   assign opcode  = ir_q[31:26];
   assign funct   = ir_q[5:0];
   assign imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};
   assign at_end  = (pc_q == PC_W'(IM_DEPTH - 1));
   assign unused_ir_bits = ^{ir_q[25:23], ir_q[20:18]};

   // Instruction class and R-type ALU op decode from the latched IR
   always_comb begin
      r_alu_op = 3'b000;
      is_rtype = 1'b0;
      if (opcode == OP_RTYPE) begin
         is_rtype = 1'b1;
         case (funct)
            6'b100000: r_alu_op = 3'b000;
            6'b100010: r_alu_op = 3'b001;
            6'b100100: r_alu_op = 3'b010;
            6'b100101: r_alu_op = 3'b011;
            6'b101010: r_alu_op = 3'b100;
            default:   is_rtype = 1'b0;
         endcase
      end
      is_addi = (opcode == OP_ADDI);
      is_beq  = (opcode == OP_BEQ);
      is_halt = (opcode == OP_HALT);
   end

   // Branch target in signed 32-bit so negative and past-the-end targets are caught
   always_comb begin
      br_target = $signed({{(32-PC_W){1'b0}}, pc_q}) + 32'sd1
                  + (bus.alu_zero ? imm_ext : 32'sd0);
      br_in_range = (br_target >= 32'sd0) && (br_target < IM_DEPTH);
   end

   // Next-state, PC, IR and retire-count logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_FETCH;
         S_FETCH: begin
            ir_d    = bus.instr;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_rtype || is_addi) state_d = S_EXEC;
            else if (is_beq)         state_d = S_BRANCH;
            else if (is_halt) begin
               state_d = S_HALT;
               retire  = 1'b1;
            end else if (at_end)     state_d = S_HALT;
            else begin
               pc_d    = pc_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC:   state_d = S_WB;
         S_WB: begin
            retire = 1'b1;
            if (at_end) state_d = S_HALT;
            else begin
               pc_d    = pc_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_BRANCH: begin
            retire = 1'b1;
            if (br_in_range) begin
               pc_d    = br_target[PC_W-1:0];
               state_d = S_FETCH;
            end else begin
               state_d = S_HALT;
            end
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
      retired_d = (retire && (retired_q != '1)) ? retired_q + 1'b1 : retired_q;
   end

   // State and architectural registers; reset wins over any in-flight instruction
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   // Moore outputs decoded from the state register and IR
   always_comb begin
      bus.ir_load      = 1'b0;
      bus.rs_sel       = 2'b00;
      bus.rt_sel       = 2'b00;
      bus.a_load       = 1'b0;
      bus.b_load       = 1'b0;
      bus.b_sel_imm    = 1'b0;
      bus.imm          = 32'd0;
      bus.alu_op       = 3'b000;
      bus.alu_out_load = 1'b0;
      bus.reg_we       = 1'b0;
      bus.wr_sel       = 2'b00;
      bus.illegal      = 1'b0;
      case (state_q)
         S_FETCH:  bus.ir_load = 1'b1;
         S_DECODE: begin
            bus.a_load  = 1'b1;
            bus.b_load  = 1'b1;
            bus.rs_sel  = ir_q[22:21];
            bus.rt_sel  = ir_q[17:16];
            bus.illegal = !(is_rtype || is_addi || is_beq || is_halt);
         end
         S_EXEC: begin
            bus.alu_out_load = 1'b1;
            bus.imm          = imm_ext;
            if (is_addi) bus.b_sel_imm = 1'b1;
            else         bus.alu_op    = r_alu_op;
         end
         S_WB: begin
            bus.reg_we = 1'b1;
            bus.wr_sel = is_addi ? ir_q[17:16] : ir_q[12:11];
         end
         S_BRANCH: bus.alu_op = 3'b001;
         default: ;
      endcase
   end

   assign bus.pc      = pc_q;
   assign bus.busy    = (state_q != S_IDLE) && (state_q != S_HALT);
   assign bus.halted  = (state_q == S_HALT);
   assign bus.retired = retired_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;
   localparam logic [31:0] HALT_W = 32'hFC00_0000;
   localparam logic [31:0] ILL_W  = 32'h5400_0000;

   logic clk = 1'b0;
   logic RST = 1'b1;
   logic [31:0] im [0:19];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_sequencer_if #(.PC_W(5), .CNT_W(8)) s1 ();
   multicycle_sequencer_if #(.PC_W(5), .CNT_W(2)) s2 ();

   assign s1.instr = (s1.pc < 5'd20) ? im[s1.pc] : 32'd0;
   assign s2.instr = (s2.pc < 5'd20) ? im[s2.pc] : 32'd0;

   multicycle_sequencer #(.IM_DEPTH(20), .PC_W(5), .CNT_W(8)) dut (
      .clk(clk), .RST(RST), .bus(s1.master));
   multicycle_sequencer #(.IM_DEPTH(20), .PC_W(5), .CNT_W(2)) dut_sat (
      .clk(clk), .RST(RST), .bus(s2.master));

   // {ir_load, a_load, b_load, b_sel_imm, alu_out_load, reg_we, illegal}
   logic [6:0] strb;
   assign strb = {s1.ir_load, s1.a_load, s1.b_load, s1.b_sel_imm,
                  s1.alu_out_load, s1.reg_we, s1.illegal};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] r_type(input logic [1:0] rs, input logic [1:0] rt,
                                          input logic [1:0] rd, input logic [5:0] fn);
      return {6'b000000, 3'b0, rs, 3'b0, rt, 3'b0, rd, 5'b0, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [1:0] rs,
                                          input logic [1:0] rt, input logic [15:0] iv);
      return {op, 3'b0, rs, 3'b0, rt, iv};
   endfunction

   task automatic fill(input logic [31:0] w);
      for (int i = 0; i < 20; i++) im[i] = w;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      s1.start = 1'b0; s2.start = 1'b0;
      s1.alu_zero = 1'b0; s2.alu_zero = 1'b0;
      tick(); tick();
      RST = 1'b0;
   endtask

   task automatic pulse_start();
      s1.start = 1'b1; s2.start = 1'b1;
      tick();
      s1.start = 1'b0; s2.start = 1'b0;
   endtask

   task automatic set_zero(input logic z);
      s1.alu_zero = z; s2.alu_zero = z;
   endtask

   task automatic wait_fetch(input logic [4:0] p, input int budget);
      int n = 0;
      while (!(s1.ir_load && s1.pc == p) && n < budget) begin
         tick();
         n++;
      end
      check($sformatf("reach_fetch_pc%0d", p), {31'd0, s1.ir_load && s1.pc == p}, 32'd1);
   endtask

   task automatic beq_case(input string nm, input logic [15:0] iv, input logic z,
                           input logic [4:0] exp_pc, input logic exp_halt);
      fill(HALT_W);
      im[0] = ILL_W; im[1] = ILL_W; im[2] = ILL_W;
      im[3] = i_type(6'b000100, 2'd0, 2'd1, iv);
      do_reset();
      pulse_start();
      wait_fetch(5'd3, 20);
      tick(); tick();
      check({nm, "_branch_aluop"}, {29'd0, s1.alu_op}, 32'd1);
      set_zero(z);
      tick();
      set_zero(1'b0);
      check({nm, "_pc"}, {27'd0, s1.pc}, {27'd0, exp_pc});
      check({nm, "_halted"}, {31'd0, s1.halted}, {31'd0, exp_halt});
      check({nm, "_retired"}, {24'd0, s1.retired}, 32'd1);
   endtask

   initial begin
      logic saw_we;
      fill(HALT_W);
      s1.start = 1'b0; s2.start = 1'b0;
      s1.alu_zero = 1'b0; s2.alu_zero = 1'b0;

      // Reset and idle
      do_reset();
      for (int i = 0; i < 5; i++) begin
         check("idle_strobes", {25'd0, strb}, 32'd0);
         check("idle_state", {29'd0, s1.busy, s1.halted, 1'b0} | {27'd0, s1.pc}, 32'd0);
         tick();
      end
      check("idle_retired", {24'd0, s1.retired}, 32'd0);

      // ADD then HALT, start held high throughout
      im[0] = r_type(2'd0, 2'd1, 2'd2, 6'b100000);
      im[1] = HALT_W;
      do_reset();
      s1.start = 1'b1; s2.start = 1'b1;
      tick();
      check("add_c1_fetch", {25'd0, strb}, 32'b1000000);
      check("add_c1_busy", {31'd0, s1.busy}, 32'd1);
      tick();
      check("add_c2_decode", {25'd0, strb}, 32'b0110000);
      check("add_c2_sel", {28'd0, s1.rs_sel, s1.rt_sel}, 32'b0001);
      tick();
      check("add_c3_exec", {25'd0, strb}, 32'b0000100);
      check("add_c3_aluop", {29'd0, s1.alu_op}, 32'd0);
      tick();
      check("add_c4_wb", {25'd0, strb}, 32'b0000010);
      check("add_c4_wrsel", {30'd0, s1.wr_sel}, 32'd2);
      tick();
      check("add_c5_fetch_pc", {26'd0, s1.ir_load, s1.pc}, {26'd0, 1'b1, 5'd1});
      check("add_c5_retired", {24'd0, s1.retired}, 32'd1);
      tick(); tick();
      check("add_c7_halted", {30'd0, s1.halted, s1.busy}, 32'b10);
      check("add_c7_retired", {24'd0, s1.retired}, 32'd2);
      tick();
      check("add_halt_ignores_start", {26'd0, s1.halted, s1.pc}, {26'd0, 1'b1, 5'd1});
      s1.start = 1'b0; s2.start = 1'b0;

      // ADDI with negative immediate
      fill(HALT_W);
      im[0] = i_type(6'b001000, 2'd1, 2'd3, 16'hFFFB);
      do_reset();
      pulse_start();
      tick(); tick();
      check("addi_exec", {25'd0, strb}, 32'b0001100);
      check("addi_imm", s1.imm, 32'hFFFF_FFFB);
      check("addi_aluop", {29'd0, s1.alu_op}, 32'd0);
      tick();
      check("addi_wrsel", {30'd0, s1.wr_sel}, 32'd3);

      // BEQ at pc 3
      beq_case("beq_taken", 16'd4, 1'b1, 5'd8, 1'b0);
      beq_case("beq_not_taken", 16'd4, 1'b0, 5'd4, 1'b0);
      beq_case("beq_negative", 16'hFFF6, 1'b1, 5'd3, 1'b1);
      beq_case("beq_last_word", 16'd15, 1'b1, 5'd19, 1'b0);
      beq_case("beq_past_end", 16'd16, 1'b1, 5'd3, 1'b1);

      // Run off the end of memory
      fill(ILL_W);
      im[19] = r_type(2'd0, 2'd1, 2'd2, 6'b100000);
      do_reset();
      pulse_start();
      wait_fetch(5'd19, 100);
      tick(); tick(); tick();
      check("end_wb", {25'd0, strb}, 32'b0000010);
      tick();
      check("end_halted_pc", {26'd0, s1.halted, s1.pc}, {26'd0, 1'b1, 5'd19});
      check("end_retired", {24'd0, s1.retired}, 32'd1);

      // Illegal opcode at pc 5, and saturation on the narrow counter
      fill(HALT_W);
      for (int i = 0; i < 5; i++) im[i] = i_type(6'b001000, 2'd0, 2'd1, 16'd1);
      im[5] = ILL_W;
      do_reset();
      pulse_start();
      wait_fetch(5'd5, 60);
      check("ill_retired_before", {24'd0, s1.retired}, 32'd5);
      tick();
      check("ill_pulse", {25'd0, strb}, 32'b0110001);
      tick();
      check("ill_next_fetch", {25'd0, s1.illegal, s1.ir_load, s1.pc}, {25'd0, 1'b0, 1'b1, 5'd6});
      check("ill_retired_after", {24'd0, s1.retired}, 32'd5);
      tick(); tick();
      check("ill_halted", {31'd0, s1.halted}, 32'd1);
      check("ill_retired_final", {24'd0, s1.retired}, 32'd6);
      check("sat_halted", {31'd0, s2.halted}, 32'd1);
      check("sat_retired", {30'd0, s2.retired}, 32'd3);

      // Reset during EXEC
      fill(HALT_W);
      im[0] = r_type(2'd1, 2'd2, 2'd3, 6'b100010);
      do_reset();
      pulse_start();
      tick(); tick();
      check("rst_mid_exec", {25'd0, strb}, 32'b0000100);
      check("rst_mid_aluop", {29'd0, s1.alu_op}, 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("rst_mid_idle", {25'd0, s1.busy, s1.halted, s1.pc}, 32'd0);
      check("rst_mid_strobes", {25'd0, strb}, 32'd0);
      saw_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (s1.reg_we || s1.busy) saw_we = 1'b1;
         tick();
      end
      check("rst_mid_no_wb", {31'd0, saw_we}, 32'd0);
      check("rst_mid_retired", {24'd0, s1.retired}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multicycle control FSM for the 4-register / A-B-ALUout datapath with 20-word instruction memory.
- Drives the PC into the instruction memory and latches the addressed word into an internal IR.
- Issues register-read selects, A/B/ALUout load strobes, ALU op and write-back strobes, one instruction at a time.
- Sits between the instruction memory (IM0..IM19 mux) and the datapath inside the top-level control wrapper.

Parameters:
IM_DEPTH, 20, number of instruction words; PC range 0..IM_DEPTH-1
PC_W, 5, PC width; must satisfy 2^PC_W >= IM_DEPTH
CNT_W, 8, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
RST  in  1  synchronous active-high reset
start  in  1  begin execution from PC 0; sampled only in IDLE
instr  in  32  instruction word IM[pc], combinational from instruction memory
alu_zero  in  1  ALU result == 0, valid in BRANCH state
pc  out  PC_W  current instruction address (registered)
ir_load  out  1  internal IR captures instr this cycle
rs_sel  out  2  register index feeding A (IR[22:21])
rt_sel  out  2  register index feeding B (IR[17:16])
a_load  out  1  A <= R[rs_sel]
b_load  out  1  B <= R[rt_sel]
b_sel_imm  out  1  ALU B operand = imm instead of B
imm  out  32  sign-extended IR[15:0]
alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
alu_out_load  out  1  ALUout <= ALU result
reg_we  out  1  R[wr_sel] <= ALUout
wr_sel  out  2  write-back register index
busy  out  1  high in any state other than IDLE and HALT
halted  out  1  high in HALT
illegal  out  1  one-cycle pulse on unrecognised opcode/funct
retired  out  CNT_W  instructions completed since reset; saturates at all-ones

Behaviour:
- Every state transition and register update, including reset, occurs on the clk rising edge.
- Reset (RST=1):
  - Next state IDLE; pc=0; IR=0; retired=0.
  - All strobes 0; busy=0; halted=0; illegal=0.
  - RST overrides every state, including mid-instruction. No partial write-back completes after RST is sampled.
- Strobes, selects, alu_op and imm are Moore outputs decoded from the state register and IR. They are 0 when not listed below.
- Decode fields: opcode=IR[31:26], funct=IR[5:0], rd=IR[12:11].
- Recognised instructions:
  - R-type: opcode 000000 with funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - ADDI: opcode 001000.
  - BEQ: opcode 000100.
  - HALT: opcode 111111.
- States:
  - IDLE: if start, go to FETCH; otherwise stay.
  - FETCH: ir_load=1; IR<=instr; go to DECODE.
  - DECODE: a_load=1, b_load=1.
    - R-type or ADDI: go to EXEC.
    - BEQ: go to BRANCH.
    - HALT: go to HALT; retired increments.
    - Other: illegal=1; treat as NOP and advance PC (see PC advance).
  - EXEC: alu_out_load=1.
    - R-type: alu_op from funct.
    - ADDI: alu_op=ADD, b_sel_imm=1.
    - Go to WB.
  - WB: reg_we=1; wr_sel=rd for R-type, rt for ADDI; retired increments; advance PC.
  - BRANCH: alu_op=SUB; retired increments.
    - If alu_zero: target = pc + 1 + imm (signed).
    - Otherwise: target = pc + 1.
    - Target computed in 32-bit signed arithmetic.
    - If target < 0 or target >= IM_DEPTH: go to HALT with pc unchanged.
    - Otherwise: pc <= target; go to FETCH.
  - HALT: halted=1. Stays until RST; start is ignored.
- PC advance (WB and illegal NOP):
  - If pc == IM_DEPTH-1: go to HALT with pc unchanged. No wrap.
  - Otherwise: pc <= pc+1; go to FETCH.
- Latency (cycles from FETCH to next FETCH or HALT):
  - R-type / ADDI: 4.
  - BEQ: 3.
  - Illegal: 2.
  - HALT: 2 (FETCH, DECODE), then halted.
- From start high in IDLE, ir_load asserts on the following cycle.
- start held high during execution has no effect.
- retired is unchanged by illegal NOPs.
- Registers may all be written, including R0. Write-back is the only register-file writer.

Test Plan:
- Reset/idle: RST 2 cycles, start=0 for 5 cycles -> pc=0, busy=0, halted=0, all strobes 0, retired=0.
- ADD sequence: IM0=ADD rd=2,rs=0,rt=1; IM1=HALT; start pulse ->
  - ir_load, a_load/b_load, alu_out_load (alu_op=000), reg_we (wr_sel=2) on cycles 1..4;
  - then FETCH pc=1; halted on cycle 7; retired=2.
- ADDI with negative imm: IR[15:0]=0xFFFB -> imm=0xFFFFFFFB, b_sel_imm=1 in EXEC, wr_sel=rt.
- BEQ taken and not taken, at pc=3 with imm=+4:
  - alu_zero=1 -> pc=8.
  - alu_zero=0 -> pc=4.
  - imm=-10 -> HALT, pc stays 3.
- End of memory, illegal opcode, saturation:
  - IM19=ADD with no HALT -> halted after WB, pc=19.
  - Opcode 010101 at pc=5 -> single illegal pulse, pc=6, retired unchanged.
  - CNT_W=2 -> retired saturates at 3.
- Reset mid-op: RST asserted in EXEC -> next cycle IDLE, reg_we never asserted, pc=0.
